// File: rtl/filter_seq.sv
// Four-phase Gray-sequenced A/B filter controller with X pass/fail capture per phase.
// Define FILTER_SEQ_ABORT_EN to end a run at the first X=0 sample instead of running all phases.
module filter_seq #(
  parameter int unsigned PHASE_LEN = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic       X,
  output logic       A,
  output logic       B,
  output logic       Busy,
  output logic       Done,
  output logic       OutResult,
  output logic [3:0] PhaseFail
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(PHASE_LEN - 1);

  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       fail_q, fail_d;
  logic             a_q, a_d, b_q, b_d;
  logic             res_q, res_d;
  logic [3:0]       pf_q, pf_d;

  logic [3:0]       fail_smp;
  logic [1:0]       phase_nxt;
  logic             finish;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    fail_d    = fail_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    pf_d      = pf_q;
    finish    = 1'b0;
    phase_nxt = phase_q + 2'd1;
    // Fail bits including this cycle's sample, so DONE reports the final sample too.
    fail_smp           = fail_q;
    fail_smp[phase_q]  = fail_q[phase_q] | ~X;

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          state_d = StRun;
          phase_d = 2'd0;
          cnt_d   = '0;
          fail_d  = 4'b0000;
          a_d     = 1'b1;
          b_d     = 1'b0;
        end
      end
      StRun: begin
        fail_d = fail_smp;
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          phase_d = phase_nxt;
          // Gray order 10 -> 11 -> 01 -> 00: one select toggles per boundary.
          a_d     = (phase_nxt == 2'd0) || (phase_nxt == 2'd1);
          b_d     = (phase_nxt == 2'd1) || (phase_nxt == 2'd2);
          if (phase_q == 2'd3) finish = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`ifdef FILTER_SEQ_ABORT_EN
        if (!X) finish = 1'b1;
`endif
        if (finish) begin
          state_d = StDone;
          phase_d = 2'd0;
          cnt_d   = '0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          pf_d    = fail_smp;
          res_d   = ~|fail_smp;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StIdle;
      phase_q <= 2'd0;
      cnt_q   <= '0;
      fail_q  <= 4'b0000;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      res_q   <= 1'b0;
      pf_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      pf_q    <= pf_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign Busy      = (state_q == StRun);
  assign Done      = (state_q == StDone);
  assign OutResult = res_q;
  assign PhaseFail = pf_q;

endmodule
